// File: rtl/seq_alu_param.sv
// Multi-cycle unsigned ALU (add/sub/shift-add mul/restoring div) with a serial operand and result bus.
// Latency: END rises 3 edges after start for add/sub/div-by-zero, WIDTH+2 edges after start for mul/div.
// Backpressure: none; BEGIN is only sampled in IDLE, requests in any other state are dropped, never queued.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   BEGIN     start request (IDLE only)
//   op_code   00 add, 01 sub, 10 mul, 11 div; latched on the start edge
//   inbus     operand A on the start edge, operand B on the next edge
//   outbus    result word0 then word1 while END=1, otherwise 0
//   END       high for exactly two cycles per operation
//   busy      high in every state except IDLE
//   div_zero  high alongside END when a divide saw B=0
module seq_alu_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BEGIN,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] inbus,
    output logic [WIDTH-1:0] outbus,
    output logic             END,
    output logic             busy,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_B,
        S_EXEC,
        S_OUT0,
        S_OUT1
    } state_t;

    state_t               state;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   p;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       dif;
    logic [WIDTH:0]       mul_hi;
    logic [WIDTH:0]       rem_try;
    logic [WIDTH-1:0]     rem_sub;
    logic                 q_bit;
    logic                 div_by_zero;
    logic                 exec_done;
    logic [2*WIDTH-1:0]   p_next;

    // Next accumulator value for one EXEC edge. p holds {hi, lo}:
    //   mul: lo starts as the multiplier A and is consumed LSB-first while the
    //        product grows in from the top.
    //   div: lo starts as the dividend A; each step shifts one dividend bit
    //        into the partial remainder (hi) and shifts a quotient bit into lo.
    always_comb begin
        sum         = {1'b0, a} + {1'b0, b};
        // Bit WIDTH of the difference is the borrow (set iff a < b).
        dif         = {1'b0, a} - {1'b0, b};
        mul_hi      = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, b};
        // Partial remainder after shifting in the next dividend bit; needs one
        // extra bit because 2*rem+1 can exceed WIDTH bits.
        rem_try     = p[2*WIDTH-1:WIDTH-1];
        q_bit       = (rem_try >= {1'b0, b});
        // When q_bit is set the true difference is < b, so WIDTH bits suffice.
        rem_sub     = rem_try[WIDTH-1:0] - b;
        div_by_zero = (b == '0);
        exec_done   = 1'b1;
        p_next      = p;
        case (op)
            OP_ADD: p_next = {{(WIDTH-1){1'b0}}, sum};
            OP_SUB: p_next = {{(WIDTH-1){1'b0}}, dif};
            OP_MUL: begin
                p_next    = p[0] ? {mul_hi, p[WIDTH-1:1]} : {1'b0, p[2*WIDTH-1:1]};
                exec_done = (cnt == CNT_W'(WIDTH - 1));
            end
            default: begin
                if (div_by_zero) begin
                    // Skip iterations: quotient all-ones, remainder = dividend.
                    p_next = {a, {WIDTH{1'b1}}};
                end else begin
                    p_next    = {(q_bit ? rem_sub : rem_try[WIDTH-1:0]),
                                 p[WIDTH-2:0], q_bit};
                    exec_done = (cnt == CNT_W'(WIDTH - 1));
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            op       <= '0;
            a        <= '0;
            b        <= '0;
            p        <= '0;
            cnt      <= '0;
            outbus   <= '0;
            END      <= 1'b0;
            busy     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (BEGIN) begin
                        a     <= inbus;
                        op    <= op_code;
                        busy  <= 1'b1;
                        state <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    b     <= inbus;
                    cnt   <= '0;
                    // Same initial accumulator serves both mul and div.
                    p     <= {{WIDTH{1'b0}}, a};
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    p   <= p_next;
                    cnt <= cnt + 1'b1;
                    if (exec_done) begin
                        // Outputs are registered, so word0 is taken from the
                        // value being written into p on this same edge.
                        outbus   <= p_next[WIDTH-1:0];
                        END      <= 1'b1;
                        div_zero <= (op == 2'b11) && div_by_zero;
                        state    <= S_OUT0;
                    end
                end
                S_OUT0: begin
                    outbus <= p[2*WIDTH-1:WIDTH];
                    state  <= S_OUT1;
                end
                S_OUT1: begin
                    outbus   <= '0;
                    END      <= 1'b0;
                    busy     <= 1'b0;
                    div_zero <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_param.sv
// Bench for seq_alu_param at WIDTH=8 and WIDTH=16, sharing one stimulus bus.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_alu_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        begin_s;
    logic [1:0]  op_s;
    logic [31:0] in_s;
    logic        sel;       // 0 drives/observes the 8-bit unit, 1 the 16-bit unit

    logic [7:0]  ob8;
    logic        end8, busy8, dz8;
    logic [15:0] ob16;
    logic        end16, busy16, dz16;

    seq_alu_param #(.WIDTH(8)) u_alu8 (
        .clk(clk), .reset(reset), .BEGIN(begin_s & ~sel), .op_code(op_s),
        .inbus(in_s[7:0]), .outbus(ob8), .END(end8), .busy(busy8), .div_zero(dz8)
    );

    seq_alu_param #(.WIDTH(16)) u_alu16 (
        .clk(clk), .reset(reset), .BEGIN(begin_s & sel), .op_code(op_s),
        .inbus(in_s[15:0]), .outbus(ob16), .END(end16), .busy(busy16), .div_zero(dz16)
    );

    logic [31:0] ob;
    logic        o_end, o_busy, o_dz;
    always_comb begin
        ob     = sel ? {16'd0, ob16} : {24'd0, ob8};
        o_end  = sel ? end16  : end8;
        o_busy = sel ? busy16 : busy8;
        o_dz   = sel ? dz16   : dz8;
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation: start, optional stray BEGIN pulse during EXEC,
    // then latency, both result words, flags and the return to IDLE.
    task automatic run_op(input int w, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit poke, input string tag);
        logic [63:0] mask, a64, b64, r, e0, e1;
        logic        edz;
        int          lat, e, extra;
        mask = (64'd1 << w) - 64'd1;
        a64  = {32'd0, a};
        b64  = {32'd0, b};
        edz  = 1'b0;
        case (op)
            2'b00: begin r = a64 + b64; e0 = r & mask; e1 = r >> w; end
            2'b01: begin e0 = (a64 - b64) & mask; e1 = (a64 < b64) ? 64'd1 : 64'd0; end
            2'b10: begin r = a64 * b64; e0 = r & mask; e1 = r >> w; end
            default: begin
                if (b64 == 0) begin e0 = mask; e1 = a64; edz = 1'b1; end
                else begin e0 = a64 / b64; e1 = a64 % b64; end
            end
        endcase
        lat = (op == 2'b10 || (op == 2'b11 && b64 != 0)) ? w + 1 : 2;

        sel = (w == 16);
        @(negedge clk);
        begin_s = 1'b1; op_s = op; in_s = a;
        @(posedge clk);                 // edge 0
        @(negedge clk);
        begin_s = 1'b0; in_s = b;
        op_s = ~op;                     // latched op must not follow the pin
        check({tag, " busy_after_start"}, {63'd0, o_busy}, 64'd1);
        e = 0;
        while (!o_end && e < 100) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (e >= 1 && !o_end) in_s = $urandom;
            if (poke) begin_s = (e == 3);
        end
        begin_s = 1'b0;
        check({tag, " latency"}, 64'(e), 64'(lat));
        check({tag, " word0"}, {32'd0, ob}, e0);
        check({tag, " dz0"}, {63'd0, o_dz}, {63'd0, edz});
        @(negedge clk);
        check({tag, " end1"}, {63'd0, o_end}, 64'd1);
        check({tag, " word1"}, {32'd0, ob}, e1);
        check({tag, " dz1"}, {63'd0, o_dz}, {63'd0, edz});
        check({tag, " busy1"}, {63'd0, o_busy}, 64'd1);
        @(negedge clk);
        check({tag, " end_fall"}, {63'd0, o_end}, 64'd0);
        check({tag, " out_zero"}, {32'd0, ob}, 64'd0);
        check({tag, " dz_clear"}, {63'd0, o_dz}, 64'd0);
        check({tag, " busy_clear"}, {63'd0, o_busy}, 64'd0);
        if (poke) begin
            extra = 0;
            repeat (w + 4) begin
                @(negedge clk);
                if (o_end) extra++;
            end
            check({tag, " no_extra_end"}, 64'(extra), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ends;
        int w, opi;
        logic [31:0] ra, rb;

        reset = 1'b1; begin_s = 1'b0; op_s = 2'b00; in_s = '0; sel = 1'b0;
        #12;
        check("reset_out8",  {56'd0, ob8},  64'd0);
        check("reset_end8",  {63'd0, end8}, 64'd0);
        check("reset_busy8", {63'd0, busy8}, 64'd0);
        check("reset_dz8",   {63'd0, dz8},  64'd0);
        check("reset_out16", {48'd0, ob16}, 64'd0);
        check("reset_busy16", {63'd0, busy16}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(8, 2'b00, 3, 2, 0, "add_3_2");
        run_op(8, 2'b00, 200, 100, 0, "add_200_100");
        run_op(8, 2'b01, 2, 3, 0, "sub_2_3");
        run_op(8, 2'b01, 9, 4, 0, "sub_9_4");
        run_op(8, 2'b10, 7, 3, 0, "mul_7_3");
        run_op(8, 2'b10, 255, 255, 0, "mul_255_255");
        run_op(8, 2'b11, 100, 7, 0, "div_100_7");
        run_op(8, 2'b11, 37, 0, 0, "div_37_0");
        run_op(8, 2'b10, 13, 11, 1, "mul_begin_pulse");

        // Reset in the middle of a multiply.
        sel = 1'b0;
        @(negedge clk);
        begin_s = 1'b1; op_s = 2'b10; in_s = 200;
        @(posedge clk);
        @(negedge clk);
        begin_s = 1'b0; in_s = 3;
        repeat (5) @(posedge clk);
        #2;
        check("mid_op_busy", {63'd0, busy8}, 64'd1);
        reset = 1'b1;
        #1;
        check("abort_out",  {56'd0, ob8},   64'd0);
        check("abort_end",  {63'd0, end8},  64'd0);
        check("abort_busy", {63'd0, busy8}, 64'd0);
        check("abort_dz",   {63'd0, dz8},   64'd0);
        @(negedge clk);
        reset = 1'b0;
        ends = 0;
        repeat (20) begin
            @(negedge clk);
            if (end8) ends++;
        end
        check("abort_no_end", 64'(ends), 64'd0);
        run_op(8, 2'b00, 1, 1, 0, "add_after_reset");

        run_op(16, 2'b10, 65535, 65535, 0, "mul16_max");
        run_op(16, 2'b11, 65535, 65535, 0, "div16_max");
        run_op(16, 2'b11, 50000, 0, 0, "div16_zero");
        run_op(16, 2'b11, 60001, 123, 0, "div16_mix");

        for (int i = 0; i < 24; i++) begin
            w   = (i < 12) ? 8 : 16;
            opi = $urandom_range(0, 3);
            ra  = $urandom_range(0, (1 << w) - 1);
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom_range(0, (1 << w) - 1);
            run_op(w, opi[1:0], ra, rb, 0, $sformatf("rand%0d_w%0d_op%0d", i, w, opi));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_alu_param.md
Name: seq_alu_param

Overview:
Parametrised successor to the team's 8-bit sequential ALU. It is a multi-cycle unsigned ALU with a BEGIN/END handshake. Operands arrive serially on a single shared input bus, and results return serially on a single shared output bus. It supports add, subtract, shift-add multiply and restoring divide at any operand width, and adds a busy indicator and divide-by-zero reporting.

Parameters:
WIDTH, 8, operand/bus width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), iteration-counter width; localparam, not overridable.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
BEGIN  input  1  start request, sampled only in IDLE
op_code  input  2  00 add, 01 sub, 10 mul, 11 div; sampled with BEGIN
inbus  input  WIDTH  operand input: A on the start edge, B on the following edge
outbus  output  WIDTH  result words, valid only while END=1, otherwise 0
END  output  1  high for exactly two consecutive cycles per operation
busy  output  1  high in every state except IDLE
div_zero  output  1  high together with END when a div had B=0; otherwise 0

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset, async, any state:
  - state=IDLE.
  - outbus=0, END=0, busy=0, div_zero=0.
  - all internal registers and the counter cleared.
  - Reset mid-operation aborts the operation; no END is produced for it.
- All arithmetic is unsigned.
- Datapath registers:
  - A, B: WIDTH bits each.
  - accumulator P: 2*WIDTH bits.
  - counter: CNT_W bits.
- IDLE, start edge (BEGIN=1 at the edge):
  - latch op_code and inbus into A.
  - go to LOAD_B.
  - BEGIN=0: stay in IDLE.
- LOAD_B, next edge: latch inbus into B, clear counter, go to EXEC. BEGIN is don't-care.
- EXEC, add/sub:
  - one edge only.
  - add: P = {carry zero-extended, A+B mod 2^WIDTH}.
  - sub: P = {borrow zero-extended, A-B mod 2^WIDTH}; borrow=1 iff A<B.
  - then go to OUT0.
- EXEC, mul (radix-2 shift-add):
  - WIDTH edges.
  - each edge adds B into the upper half of P when the current multiplier LSB is 1, then shifts right.
  - counter increments each edge; leave EXEC when counter reaches WIDTH-1 on that edge.
  - result: P = A*B (2*WIDTH bits).
- EXEC, div (restoring):
  - WIDTH edges, quotient bit resolved MSB-first; same counter rule as mul.
  - result: word0 = quotient, word1 = remainder.
  - B=0: skip the iterations entirely (one EXEC edge); word0 = all-ones, word1 = A, div_zero flag set.
- OUT0: END=1, outbus = word0 (low product / quotient / sum / difference).
- OUT1: END=1, outbus = word1 (high product / remainder / carry / borrow). Next edge returns to IDLE.
- Latency, counting the start edge as edge 0:
  - add/sub: END rises after edge 2.
  - mul/div: END rises after edge WIDTH+1.
  - div by zero: END rises after edge 2.
- Outputs are registered: outbus, END and div_zero change only on clock edges or reset.
- BEGIN high in any non-IDLE state is ignored and never queued.
- Back-to-back: earliest next start edge is the first edge after returning to IDLE. BEGIN held high continuously restarts on that edge; inbus must hold the new A then.
- op_code is latched; changes after the start edge have no effect.
- outbus=0 whenever END=0.
- div_zero=0 outside OUT0/OUT1.

Test Plan (WIDTH=8 unless noted):
- Add: BEGIN=1, op 00, A=3 then B=2 -> END after edge 2; words 5, 0. Then A=200, B=100 -> words 44, 1.
- Sub: A=2, B=3 -> words 255, 1. Then A=9, B=4 -> words 5, 0. busy=1 from edge 0 until END falls.
- Mul: A=7, B=3 -> END after edge 9; words 21, 0. Then A=255, B=255 -> words 0x01, 0xFE.
- Div: A=100, B=7 -> END after edge 9; words 14, 2, div_zero=0. Then A=37, B=0 -> END after edge 2; words 255, 37, div_zero=1 on both END cycles.
- Robustness: BEGIN pulsed during EXEC of a mul -> ignored, exactly two END cycles. Reset asserted at EXEC edge 4 of a mul -> all outputs 0 immediately, no END. A following add of 1+1 -> words 2, 0.
- Width sweep: repeat the mul/div checks with WIDTH=16 and A=65535, B=65535 -> mul words 0x0001, 0xFFFE, END after edge 17. Random unsigned pairs checked against the reference model.
